// File: rtl/bpu_ras_param_pkg.sv
// Shared types and defaults for the parametrised BPU return address stack.
// RAS_DEPTH / RAS_ADDR_W are the default stack depth and address width.
// ras_ckpt_t is the {ptr, cnt} checkpoint travelling with a predicted branch
// (sized for the default depth). Optional feature macro: BPU_RAS_RECUR_CNT_EN.
package bpu_ras_param_pkg;

    localparam int unsigned RAS_DEPTH  = 8;
    localparam int unsigned RAS_ADDR_W = 32;
    localparam int unsigned RAS_PTR_W  = $clog2(RAS_DEPTH);

    // Per-entry repeat counter used when recursion compression is enabled.
    localparam int unsigned RAS_RC_W = 3;
    typedef logic [RAS_RC_W-1:0] ras_rc_t;
    localparam ras_rc_t RAS_RC_MAX = '1;

    typedef struct packed {
        logic [RAS_PTR_W-1:0] ptr;
        logic [RAS_PTR_W:0]   cnt;
    } ras_ckpt_t;

endpackage

// File: rtl/bpu_ras_param_if.sv
// Predictor <-> return address stack interface.
// master: predictor / verify side (push, pop, flush, restore requests).
// slave : the stack (top of stack and checkpoint outputs).
interface bpu_ras_param_if
    import bpu_ras_param_pkg::*;
#(
    parameter int unsigned DEPTH  = RAS_DEPTH,
    parameter int unsigned ADDR_W = RAS_ADDR_W
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic              flush;
    logic              push_valid;
    logic [ADDR_W-1:0] push_addr;
    logic              pop_valid;
    logic              top_valid;
    logic [ADDR_W-1:0] top_addr;
    logic [PTR_W-1:0]  ckpt_ptr;
    logic [PTR_W:0]    ckpt_cnt;
    logic              restore_valid;
    logic [PTR_W-1:0]  restore_ptr;
    logic [PTR_W:0]    restore_cnt;

    modport master (
        output flush, push_valid, push_addr, pop_valid,
               restore_valid, restore_ptr, restore_cnt,
        input  top_valid, top_addr, ckpt_ptr, ckpt_cnt
    );

    modport slave (
        input  flush, push_valid, push_addr, pop_valid,
               restore_valid, restore_ptr, restore_cnt,
        output top_valid, top_addr, ckpt_ptr, ckpt_cnt
    );

endinterface

// File: rtl/bpu_ras_param.sv
// Parametrised circular return address stack for the branch predictor.
// Calls push their return address, returns pop a predicted target. Overflow
// overwrites the oldest entry. A {ptr, cnt} checkpoint is exported every cycle
// so verify can roll back speculative push/pop; flush empties the stack.
// Ports: clk, reset (sync, active-high), bus (bpu_ras_param_if.slave):
//   flush, push_valid/push_addr, pop_valid, restore_valid/ptr/cnt in;
//   top_valid, top_addr, ckpt_ptr, ckpt_cnt out (combinational from state).
// Optional macro BPU_RAS_RECUR_CNT_EN: per-entry 3-bit repeat counters that
// fold repeated pushes of the same return address into one entry.
module bpu_ras_param
    import bpu_ras_param_pkg::*;
#(
    parameter int unsigned DEPTH  = RAS_DEPTH,
    parameter int unsigned ADDR_W = RAS_ADDR_W
) (
    input logic              clk,
    input logic              reset,
    bpu_ras_param_if.slave   bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_FULL = CNT_W'(DEPTH);
    localparam ptr_t PTR_RST  = PTR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] mem [DEPTH];
    ptr_t              tos;
    ptr_t              tos_nxt;
    cnt_t              cnt;
    cnt_t              cnt_nxt;
    ptr_t              tos_inc;
    ptr_t              tos_dec;
    logic              mem_we;
    ptr_t              mem_idx;
    logic              push_merge;
    logic              pop_merge;

`ifdef BPU_RAS_RECUR_CNT_EN
    ras_rc_t           rc [DEPTH];
    logic              rc_we;
    ptr_t              rc_idx;
    ras_rc_t           rc_wdata;

    // A push of the address already on top folds into its repeat counter.
    assign push_merge = (cnt != '0) && (bus.push_addr == mem[tos])
                        && (rc[tos] != RAS_RC_MAX);
    assign pop_merge  = (rc[tos] != '0);
`else
    assign push_merge = 1'b0;
    assign pop_merge  = 1'b0;
`endif

    assign tos_inc = tos + PTR_W'(1);
    assign tos_dec = tos - PTR_W'(1);

    // Next-state: reset > flush > restore > push/pop.
    always_comb begin
        tos_nxt = tos;
        cnt_nxt = cnt;
        mem_we  = 1'b0;
        mem_idx = tos;
`ifdef BPU_RAS_RECUR_CNT_EN
        rc_we    = 1'b0;
        rc_idx   = tos;
        rc_wdata = '0;
`endif
        if (bus.flush) begin
            cnt_nxt = '0;
        end else if (bus.restore_valid) begin
            tos_nxt = bus.restore_ptr;
            cnt_nxt = bus.restore_cnt;
        end else if (bus.push_valid && bus.pop_valid && (cnt != '0)) begin
            // Call-through-return replaces the top entry in place.
            mem_we  = 1'b1;
            mem_idx = tos;
`ifdef BPU_RAS_RECUR_CNT_EN
            rc_we    = 1'b1;
            rc_idx   = tos;
            rc_wdata = '0;
`endif
        end else if (bus.push_valid) begin
            if (push_merge) begin
`ifdef BPU_RAS_RECUR_CNT_EN
                rc_we    = 1'b1;
                rc_idx   = tos;
                rc_wdata = rc[tos] + RAS_RC_W'(1);
`endif
            end else begin
                tos_nxt = tos_inc;
                cnt_nxt = (cnt == CNT_FULL) ? cnt : cnt + CNT_W'(1);
                mem_we  = 1'b1;
                mem_idx = tos_inc;
`ifdef BPU_RAS_RECUR_CNT_EN
                rc_we    = 1'b1;
                rc_idx   = tos_inc;
                rc_wdata = '0;
`endif
            end
        end else if (bus.pop_valid) begin
            if (pop_merge) begin
`ifdef BPU_RAS_RECUR_CNT_EN
                rc_we    = 1'b1;
                rc_idx   = tos;
                rc_wdata = rc[tos] - RAS_RC_W'(1);
`endif
            end else if (cnt != '0) begin
                tos_nxt = tos_dec;
                cnt_nxt = cnt - CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tos <= PTR_RST;
            cnt <= '0;
        end else begin
            tos <= tos_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Entry storage is not reset; a request during reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[mem_idx] <= bus.push_addr;
        end
    end

`ifdef BPU_RAS_RECUR_CNT_EN
    // Repeat counters clear on reset only; flush/restore leave them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                rc[i] <= '0;
            end
        end else if (rc_we) begin
            rc[rc_idx] <= rc_wdata;
        end
    end
`endif

    assign bus.top_valid = (cnt != '0);
    assign bus.top_addr  = mem[tos];
    assign bus.ckpt_ptr  = tos;
    assign bus.ckpt_cnt  = cnt;

endmodule

// File: tb/tb_bpu_ras_param.sv
// Self-checking bench for bpu_ras_param: directed scenarios plus a randomized
// run against an integer-level model of the return address stack.
module tb_bpu_ras_param;

    localparam int D  = 8;
    localparam int AW = 32;
`ifdef BPU_RAS_RECUR_CNT_EN
    localparam bit RECUR = 1'b1;
`else
    localparam bit RECUR = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bpu_ras_param_if #(.DEPTH(D), .ADDR_W(AW)) bus ();

    bpu_ras_param #(.DEPTH(D), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a ring of entries, an integer top index and a count.
    logic [AW-1:0] m_mem [D];
    int            m_rc  [D];
    int            m_tos;
    int            m_cnt;

    task automatic model_edge(input bit rst, input bit fl, input bit rv, input int rp,
                              input int rcn, input bit pv, input logic [AW-1:0] pa,
                              input bit ppv);
        if (rst) begin
            m_tos = D - 1;
            m_cnt = 0;
            for (int i = 0; i < D; i++) m_rc[i] = 0;
        end else if (fl) begin
            m_cnt = 0;
        end else if (rv) begin
            m_tos = rp;
            m_cnt = rcn;
        end else if (pv && ppv && m_cnt > 0) begin
            m_mem[m_tos] = pa;
            m_rc[m_tos]  = 0;
        end else if (pv) begin
            if (RECUR && m_cnt > 0 && pa == m_mem[m_tos] && m_rc[m_tos] < 7) begin
                m_rc[m_tos] = m_rc[m_tos] + 1;
            end else begin
                m_tos        = (m_tos + 1) % D;
                m_mem[m_tos] = pa;
                m_rc[m_tos]  = 0;
                m_cnt        = (m_cnt + 1 > D) ? D : m_cnt + 1;
            end
        end else if (ppv) begin
            if (RECUR && m_rc[m_tos] > 0) begin
                m_rc[m_tos] = m_rc[m_tos] - 1;
            end else if (m_cnt > 0) begin
                m_tos = (m_tos + D - 1) % D;
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    // One clock: drive at negedge, model tracks the edge, return at next negedge.
    task automatic step(input bit rst, input bit fl, input bit rv, input int rp,
                        input int rcn, input bit pv, input logic [AW-1:0] pa,
                        input bit ppv);
        reset             = rst;
        bus.flush         = fl;
        bus.restore_valid = rv;
        bus.restore_ptr   = 3'(rp);
        bus.restore_cnt   = 4'(rcn);
        bus.push_valid    = pv;
        bus.push_addr     = pa;
        bus.pop_valid     = ppv;
        @(posedge clk);
        model_edge(rst, fl, rv, rp, rcn, pv, pa, ppv);
        @(negedge clk);
    endtask

    task automatic do_reset();  step(1, 0, 0, 0, 0, 0, '0, 0); endtask
    task automatic do_push(input logic [AW-1:0] a); step(0, 0, 0, 0, 0, 1, a, 0); endtask
    task automatic do_pop();    step(0, 0, 0, 0, 0, 0, '0, 1); endtask
    task automatic do_idle();   step(0, 0, 0, 0, 0, 0, '0, 0); endtask

    task automatic test_reset();
        do_reset();
        do_idle();
        checks++;
        if (bus.top_valid !== 1'b0) begin
            errors++; $display("FAIL reset_top_valid got %0b expected 0", bus.top_valid);
        end
        checks++;
        if (bus.ckpt_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_cnt got %0d expected 0", bus.ckpt_cnt);
        end
        checks++;
        if (bus.ckpt_ptr !== 3'd7) begin
            errors++; $display("FAIL reset_ptr got %0d expected 7", bus.ckpt_ptr);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        do_push(32'h8000_0010);
        do_push(32'h8000_0020);
        checks++;
        if (bus.top_valid !== 1'b1 || bus.top_addr !== 32'h8000_0020 || bus.ckpt_cnt !== 4'd2) begin
            errors++; $display("FAIL push2 got v=%0b a=%h c=%0d expected v=1 a=80000020 c=2",
                               bus.top_valid, bus.top_addr, bus.ckpt_cnt);
        end
        do_pop();
        checks++;
        if (bus.top_addr !== 32'h8000_0010 || bus.ckpt_cnt !== 4'd1) begin
            errors++; $display("FAIL pop1 got a=%h c=%0d expected a=80000010 c=1",
                               bus.top_addr, bus.ckpt_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [AW-1:0] exp_a;
        do_reset();
        for (int i = 1; i <= 9; i++) do_push(AW'(i * 32'h100));
        checks++;
        if (bus.ckpt_cnt !== 4'd8 || bus.top_addr !== 32'h900) begin
            errors++; $display("FAIL overflow_full got c=%0d a=%h expected c=8 a=900",
                               bus.ckpt_cnt, bus.top_addr);
        end
        for (int i = 0; i < 8; i++) begin
            exp_a = 32'h900 - AW'(i) * 32'h100;
            checks++;
            if (bus.top_valid !== 1'b1 || bus.top_addr !== exp_a) begin
                errors++; $display("FAIL overflow_pop%0d got v=%0b a=%h expected v=1 a=%h",
                                   i, bus.top_valid, bus.top_addr, exp_a);
            end
            do_pop();
        end
        checks++;
        if (bus.top_valid !== 1'b0) begin
            errors++; $display("FAIL overflow_empty got v=%0b expected 0", bus.top_valid);
        end
        do_pop();
        checks++;
        if (bus.ckpt_cnt !== 4'd0 || bus.top_valid !== 1'b0) begin
            errors++; $display("FAIL underflow got c=%0d v=%0b expected c=0 v=0",
                               bus.ckpt_cnt, bus.top_valid);
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        do_push(32'h10);
        do_push(32'h20);
        step(0, 0, 0, 0, 0, 1, 32'h44, 1);
        checks++;
        if (bus.top_addr !== 32'h44 || bus.ckpt_cnt !== 4'd2) begin
            errors++; $display("FAIL push_pop_same got a=%h c=%0d expected a=44 c=2",
                               bus.top_addr, bus.ckpt_cnt);
        end
        do_pop();
        checks++;
        if (bus.top_addr !== 32'h10 || bus.ckpt_cnt !== 4'd1) begin
            errors++; $display("FAIL push_pop_after got a=%h c=%0d expected a=10 c=1",
                               bus.top_addr, bus.ckpt_cnt);
        end
        // Simultaneous push+pop on an empty stack acts as a plain push.
        do_reset();
        step(0, 0, 0, 0, 0, 1, 32'h66, 1);
        checks++;
        if (bus.top_addr !== 32'h66 || bus.ckpt_cnt !== 4'd1) begin
            errors++; $display("FAIL push_pop_empty got a=%h c=%0d expected a=66 c=1",
                               bus.top_addr, bus.ckpt_cnt);
        end
    endtask

    task automatic test_restore();
        do_reset();
        do_push(32'h11);
        do_push(32'h22);
        do_push(32'h33);
        checks++;
        if (bus.ckpt_ptr !== 3'd2 || bus.ckpt_cnt !== 4'd3) begin
            errors++; $display("FAIL ckpt got p=%0d c=%0d expected p=2 c=3",
                               bus.ckpt_ptr, bus.ckpt_cnt);
        end
        do_pop();
        do_pop();
        do_push(32'h55);
        step(0, 0, 1, 2, 3, 0, '0, 0);
        checks++;
        if (bus.ckpt_ptr !== 3'd2 || bus.ckpt_cnt !== 4'd3 || bus.top_addr !== 32'h33) begin
            errors++; $display("FAIL restore got p=%0d c=%0d a=%h expected p=2 c=3 a=33",
                               bus.ckpt_ptr, bus.ckpt_cnt, bus.top_addr);
        end
        // The overwritten entry below the top is not recovered.
        do_pop();
        checks++;
        if (bus.top_addr !== 32'h55) begin
            errors++; $display("FAIL restore_stale got a=%h expected a=55", bus.top_addr);
        end
    endtask

    task automatic test_priority();
        do_reset();
        for (int i = 1; i <= 4; i++) do_push(AW'(i));
        step(0, 1, 1, 3, 4, 1, 32'h77, 1);
        checks++;
        if (bus.ckpt_cnt !== 4'd0 || bus.top_valid !== 1'b0 || bus.ckpt_ptr !== 3'd3) begin
            errors++; $display("FAIL flush_restore got c=%0d v=%0b p=%0d expected c=0 v=0 p=3",
                               bus.ckpt_cnt, bus.top_valid, bus.ckpt_ptr);
        end
        do_push(32'h88);
        step(1, 0, 0, 0, 0, 1, 32'h99, 0);
        checks++;
        if (bus.ckpt_cnt !== 4'd0 || bus.ckpt_ptr !== 3'd7) begin
            errors++; $display("FAIL reset_push got c=%0d p=%0d expected c=0 p=7",
                               bus.ckpt_cnt, bus.ckpt_ptr);
        end
        // Restore beats a same-cycle push.
        do_push(32'h1);
        step(0, 0, 1, 5, 0, 1, 32'h2, 0);
        checks++;
        if (bus.ckpt_cnt !== 4'd0 || bus.ckpt_ptr !== 3'd5) begin
            errors++; $display("FAIL restore_push got c=%0d p=%0d expected c=0 p=5",
                               bus.ckpt_cnt, bus.ckpt_ptr);
        end
    endtask

`ifdef BPU_RAS_RECUR_CNT_EN
    task automatic test_recur();
        do_reset();
        for (int i = 0; i < 3; i++) do_push(32'hA0);
        checks++;
        if (bus.ckpt_cnt !== 4'd1 || bus.top_addr !== 32'hA0) begin
            errors++; $display("FAIL recur_push got c=%0d a=%h expected c=1 a=a0",
                               bus.ckpt_cnt, bus.top_addr);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.top_valid !== 1'b1 || bus.top_addr !== 32'hA0) begin
                errors++; $display("FAIL recur_pop%0d got v=%0b a=%h expected v=1 a=a0",
                                   i, bus.top_valid, bus.top_addr);
            end
            do_pop();
        end
        checks++;
        if (bus.top_valid !== 1'b0) begin
            errors++; $display("FAIL recur_empty got v=%0b expected 0", bus.top_valid);
        end
    endtask
`endif

    task automatic test_random();
        int ck_p [$];
        int ck_c [$];
        int r;
        int k;
        bit rst, fl, rv, pv, ppv;
        logic [AW-1:0] pa;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            ck_p.push_back(m_tos);
            ck_c.push_back(m_cnt);
            if (ck_p.size() > 12) begin
                void'(ck_p.pop_front());
                void'(ck_c.pop_front());
            end
            r   = int'($urandom_range(0, 199));
            rst = (r == 0);
            fl  = (r >= 1 && r <= 4);
            rv  = (r >= 5 && r <= 14);
            pv  = ($urandom_range(0, 99) < 50);
            ppv = ($urandom_range(0, 99) < 45);
            pa  = ($urandom_range(0, 1) == 0) ? AW'(32'h1000 + 32'h10 * $urandom_range(0, 3))
                                              : AW'($urandom);
            k   = int'($urandom_range(0, ck_p.size() - 1));
            step(rst, fl, rv, ck_p[k], ck_c[k], pv, pa, ppv);
            checks++;
            if (bus.ckpt_ptr !== 3'(m_tos) || bus.ckpt_cnt !== 4'(m_cnt)) begin
                errors++; $display("FAIL rand_state@%0d got p=%0d c=%0d expected p=%0d c=%0d",
                                   n, bus.ckpt_ptr, bus.ckpt_cnt, m_tos, m_cnt);
            end
            checks++;
            if (bus.top_valid !== (m_cnt != 0)) begin
                errors++; $display("FAIL rand_valid@%0d got %0b expected %0b",
                                   n, bus.top_valid, (m_cnt != 0));
            end
            if (m_cnt != 0) begin
                checks++;
                if (bus.top_addr !== m_mem[m_tos]) begin
                    errors++; $display("FAIL rand_top@%0d got %h expected %h",
                                       n, bus.top_addr, m_mem[m_tos]);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_tos  = D - 1;
        m_cnt  = 0;
        for (int i = 0; i < D; i++) begin
            m_mem[i] = '0;
            m_rc[i]  = 0;
        end
        reset             = 1'b1;
        bus.flush         = 1'b0;
        bus.push_valid    = 1'b0;
        bus.push_addr     = '0;
        bus.pop_valid     = 1'b0;
        bus.restore_valid = 1'b0;
        bus.restore_ptr   = '0;
        bus.restore_cnt   = '0;

        test_reset();
        test_push_pop();
        test_overflow();
        test_call_ret();
        test_restore();
        test_priority();
`ifdef BPU_RAS_RECUR_CNT_EN
        test_recur();
`endif
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
